// File: rtl/sf500_pkg.sv
// Shared definitions for the SF500 accelerator bus glue.
// Provides the 6800-cycle FSM state type, the interrupt-acknowledge function
// code, and default E clock timing constants (C7M / 10, 4 cycles high).
package sf500_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        VMA  = 2'd2,
        ACK  = 2'd3
    } vpa_state_e;

    localparam logic [2:0] FC_IACK = 3'b111;

    localparam int unsigned E_DIV_DEFAULT       = 10;
    localparam int unsigned E_HIGH_DEFAULT      = 4;
    localparam int unsigned VMA_LEAD_DEFAULT    = 2;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/e_clock_div.sv
// E clock divider: free-running counter ecnt (0..E_DIV-1) and registered E,
// high for the last E_HIGH counts of each period.
// Ports:
//   clk, rst_n   - system clock, synchronous active-low reset
//   e            - registered E clock
//   at_vma_point - high in the cycle before ecnt reaches the VMA point
//                  (E_DIV-E_HIGH-VMA_LEAD)
//   at_last_high - high in the cycle before ecnt reaches E_DIV-1
//   at_wrap      - high in the cycle before ecnt wraps to 0
// The strobes lead by one cycle so that registered outputs computed from them
// change exactly on the named count.
module e_clock_div
    import sf500_pkg::*;
#(
    parameter int unsigned E_DIV    = E_DIV_DEFAULT,
    parameter int unsigned E_HIGH   = E_HIGH_DEFAULT,
    parameter int unsigned VMA_LEAD = VMA_LEAD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic e,
    output logic at_vma_point,
    output logic at_last_high,
    output logic at_wrap
);

    localparam int unsigned CNT_W = $clog2(E_DIV);

    localparam logic [CNT_W-1:0] E_RISE   = CNT_W'(E_DIV - E_HIGH);
    localparam logic [CNT_W-1:0] VMA_PRE  = CNT_W'(E_DIV - E_HIGH - VMA_LEAD - 1);
    localparam logic [CNT_W-1:0] LAST_PRE = CNT_W'(E_DIV - 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(E_DIV - 1);

    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             e_q, e_d;
    logic             at_vma_point_q, at_vma_point_d;
    logic             at_last_high_q, at_last_high_d;
    logic             at_wrap_q, at_wrap_d;

    // Next count and strobes derived from it, so flops line up with ecnt_q.
    always_comb begin : div_next
        ecnt_d         = (ecnt_q == LAST) ? '0 : ecnt_q + CNT_W'(1);
        e_d            = (ecnt_d >= E_RISE);
        at_vma_point_d = (ecnt_d == VMA_PRE);
        at_last_high_d = (ecnt_d == LAST_PRE);
        at_wrap_d      = (ecnt_d == LAST);
    end

    always_ff @(posedge clk) begin : div_reg
        if (!rst_n) begin
            ecnt_q         <= '0;
            e_q            <= 1'b0;
            at_vma_point_q <= (VMA_PRE == '0);
            at_last_high_q <= 1'b0;
            at_wrap_q      <= 1'b0;
        end else begin
            ecnt_q         <= ecnt_d;
            e_q            <= e_d;
            at_vma_point_q <= at_vma_point_d;
            at_last_high_q <= at_last_high_d;
            at_wrap_q      <= at_wrap_d;
        end
    end

    assign e            = e_q;
    assign at_vma_point = at_vma_point_q;
    assign at_last_high = at_last_high_q;
    assign at_wrap      = at_wrap_q;

endmodule

// File: rtl/e_clock_vpa_ctrl.sv
// 6800-peripheral cycle controller: generates E from C7M, runs the VPA_n /
// VMA_n handshake, and produces DTACK_CPU_n (own acknowledge for synchronous
// peripheral cycles, synchronised DTACK_MB_n pass-through otherwise).
// Optional build macro SF500_AUTOVEC_EN: IACK cycles (FC=111) with VPA_n low
// are left to the CPU's own autovectoring (no VMA, no DTACK, pad not driven).
// Ports:
//   C7M, RESET_n           - system clock, synchronous active-low reset
//   AS_CPU_n, VPA_n        - CPU strobes (asynchronous)
//   FC[2:0]                - CPU function code
//   DTACK_MB_n             - motherboard DTACK (asynchronous)
//   E, VMA_n, DTACK_CPU_n  - registered bus outputs
//   DTACK_OE               - registered drive enable for the DTACK_CPU_n pad
module e_clock_vpa_ctrl
    import sf500_pkg::*;
#(
    parameter int unsigned E_DIV       = E_DIV_DEFAULT,
    parameter int unsigned E_HIGH      = E_HIGH_DEFAULT,
    parameter int unsigned VMA_LEAD    = VMA_LEAD_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       C7M,
    input  logic       RESET_n,
    input  logic       AS_CPU_n,
    input  logic       VPA_n,
    input  logic [2:0] FC,
    input  logic       DTACK_MB_n,
    output logic       E,
    output logic       VMA_n,
    output logic       DTACK_CPU_n,
    output logic       DTACK_OE
);

    logic at_vma_point, at_last_high, at_wrap;

    e_clock_div #(
        .E_DIV   (E_DIV),
        .E_HIGH  (E_HIGH),
        .VMA_LEAD(VMA_LEAD)
    ) u_div (
        .clk         (C7M),
        .rst_n       (RESET_n),
        .e           (E),
        .at_vma_point(at_vma_point),
        .at_last_high(at_last_high),
        .at_wrap     (at_wrap)
    );

    // Input synchronisers; each stage holds {DTACK_MB_n, VPA_n, AS_CPU_n}.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic as_s, vpa_s, dtmb_s;

    always_comb begin : sync_shift
        sync_d    = sync_q;
        sync_d[0] = {DTACK_MB_n, VPA_n, AS_CPU_n};
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign as_s   = sync_q[SYNC_STAGES-1][0];
    assign vpa_s  = sync_q[SYNC_STAGES-1][1];
    assign dtmb_s = sync_q[SYNC_STAGES-1][2];

    logic autovec_c;

`ifdef SF500_AUTOVEC_EN
    // FC follows the same pipeline so it stays aligned with as_s / vpa_s.
    logic [SYNC_STAGES-1:0][2:0] fc_sync_q, fc_sync_d;

    always_comb begin : fc_shift
        fc_sync_d    = fc_sync_q;
        fc_sync_d[0] = FC;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            fc_sync_d[i] = fc_sync_q[i-1];
        end
    end

    always_ff @(posedge C7M) begin : fc_sync_reg
        if (!RESET_n) begin
            fc_sync_q <= '1;
        end else begin
            fc_sync_q <= fc_sync_d;
        end
    end

    assign autovec_c = (fc_sync_q[SYNC_STAGES-1] == FC_IACK) && !vpa_s;
`else
    logic unused_fc;
    assign unused_fc = ^FC;
    assign autovec_c = 1'b0;
`endif

    vpa_state_e state_q, state_d;
    logic       vma_n_q, vma_n_d;
    logic       dtack_q, dtack_d;
    logic       dtack_oe_q, dtack_oe_d;

    // State register.
    always_ff @(posedge C7M) begin : state_reg
        if (!RESET_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. A cycle whose AS drops during VMA completes the E period
    // without acknowledging and returns to IDLE at the wrap.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: if (!as_s && !vpa_s && !autovec_c) state_d = SYNC;
            SYNC: begin
                if (as_s)              state_d = IDLE;
                else if (at_vma_point) state_d = VMA;
            end
            VMA: begin
                if (at_last_high && !as_s) state_d = ACK;
                else if (at_wrap)          state_d = IDLE;
            end
            ACK:     if (as_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state. VMA_n stays low through the
    // VMA->ACK step (last E-high cycle) and rises on the first ACK cycle,
    // which always coincides with the wrap to ecnt 0.
    always_comb begin : output_decode
        vma_n_d    = 1'b1;
        dtack_d    = 1'b1;
        dtack_oe_d = 1'b0;
        if ((state_d == VMA) || ((state_q == VMA) && (state_d == ACK))) begin
            vma_n_d = 1'b0;
        end
        case (state_d)
            IDLE:    dtack_d = autovec_c ? 1'b1 : dtmb_s;
            ACK:     dtack_d = 1'b0;
            default: dtack_d = 1'b1;
        endcase
        dtack_oe_d = (state_d == ACK) || (!as_s && !autovec_c);
    end

    always_ff @(posedge C7M) begin : out_reg
        if (!RESET_n) begin
            sync_q     <= '1;
            vma_n_q    <= 1'b1;
            dtack_q    <= 1'b1;
            dtack_oe_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            vma_n_q    <= vma_n_d;
            dtack_q    <= dtack_d;
            dtack_oe_q <= dtack_oe_d;
        end
    end

    assign VMA_n       = vma_n_q;
    assign DTACK_CPU_n = dtack_q;
    assign DTACK_OE    = dtack_oe_q;

endmodule

// File: tb/tb_e_clock_vpa_ctrl.sv
// Directed bench for e_clock_vpa_ctrl: default instance plus a second
// instance at E_DIV=12, E_HIGH=5, VMA_LEAD=3, SYNC_STAGES=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_e_clock_vpa_ctrl;

    logic       C7M = 1'b0;
    logic       RESET_n = 1'b0;
    logic       as_n = 1'b1, vpa_n = 1'b1, dtmb_n = 1'b1;
    logic [2:0] fc = 3'b000;
    logic       e, vma_n, dtack_n, dtack_oe;

    logic       as2_n = 1'b1, vpa2_n = 1'b1, dtmb2_n = 1'b1;
    logic [2:0] fc2 = 3'b000;
    logic       e2, vma2_n, dtack2_n, dtack2_oe;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n = 0;

    // Hand-derived per-cycle vectors (index k-1 for the k-th tick).
    logic [0:9]  exp_vma_a  = 10'b1110000001;
    logic [0:9]  exp_dt_a   = 10'b1111111100;
    logic [0:9]  exp_oe_a   = 10'b0011111111;
    logic [0:2]  exp_dt_rel = 3'b001;
    logic [0:2]  exp_oe_rel = 3'b110;
    logic [0:5]  exp_vma_c  = 6'b000001;
    logic [0:8]  exp_dt_d   = 9'b110000011;
    logic [0:12] exp_vma_g  = 13'b1111000000001;
    logic [0:12] exp_dt_g   = 13'b1111111111100;

    always #5 C7M = ~C7M;

    e_clock_vpa_ctrl u_dut (
        .C7M        (C7M),
        .RESET_n    (RESET_n),
        .AS_CPU_n   (as_n),
        .VPA_n      (vpa_n),
        .FC         (fc),
        .DTACK_MB_n (dtmb_n),
        .E          (e),
        .VMA_n      (vma_n),
        .DTACK_CPU_n(dtack_n),
        .DTACK_OE   (dtack_oe)
    );

    e_clock_vpa_ctrl #(
        .E_DIV      (12),
        .E_HIGH     (5),
        .VMA_LEAD   (3),
        .SYNC_STAGES(3)
    ) u_dut2 (
        .C7M        (C7M),
        .RESET_n    (RESET_n),
        .AS_CPU_n   (as2_n),
        .VPA_n      (vpa2_n),
        .FC         (fc2),
        .DTACK_MB_n (dtmb2_n),
        .E          (e2),
        .VMA_n      (vma2_n),
        .DTACK_CPU_n(dtack2_n),
        .DTACK_OE   (dtack2_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge C7M);
        #1;
        n++;
    endtask

    task automatic wait_ec1(input int unsigned ec);
        while ((n % 10) != ec) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned lows;
        int unsigned first_k;
        logic        dt17, dt18;

        // Reset state
        repeat (3) tick();
        check("rst_e",     32'(e),        32'd0);
        check("rst_vma",   32'(vma_n),    32'd1);
        check("rst_dtack", 32'(dtack_n),  32'd1);
        check("rst_oe",    32'(dtack_oe), 32'd0);
        check("rst_e2",    32'(e2),       32'd0);
        RESET_n = 1'b1;
        n = 0;

        // E duty for both instances
        for (int i = 0; i < 24; i++) begin
            tick();
            check("e_duty",  32'(e),  32'((n % 10) >= 6));
            check("e2_duty", 32'(e2), 32'((n % 12) >= 7));
        end
        check("idle_vma",   32'(vma_n),    32'd1);
        check("idle_dtack", 32'(dtack_n),  32'd1);
        check("idle_oe",    32'(dtack_oe), 32'd0);

        // Early VPA: SYNC at ecnt 3, VMA_n low 4..9, DTACK low from 9
        wait_ec1(0);
        as_n = 1'b0; vpa_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("early_vma",   32'(vma_n),    32'(exp_vma_a[k-1]));
            check("early_dtack", 32'(dtack_n),  32'(exp_dt_a[k-1]));
            check("early_oe",    32'(dtack_oe), 32'(exp_oe_a[k-1]));
        end
        repeat (2) tick();
        as_n = 1'b1; vpa_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("early_release_dtack", 32'(dtack_n),  32'(exp_dt_rel[k-1]));
            check("early_release_oe",    32'(dtack_oe), 32'(exp_oe_rel[k-1]));
        end

        // Late VPA: misses this period, VMA_n low at ecnt 4..9 of the next
        wait_ec1(1);
        as_n = 1'b0; vpa_n = 1'b0;
        lows = 0; first_k = 0; dt17 = 1'bx; dt18 = 1'bx;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (vma_n == 1'b0) begin
                lows++;
                if (first_k == 0) first_k = k;
            end
            if (k == 17) dt17 = dtack_n;
            if (k == 18) dt18 = dtack_n;
        end
        check("late_vma_width", 32'(lows),    32'd6);
        check("late_vma_first", 32'(first_k), 32'd13);
        check("late_dtack_pre", 32'(dt17),    32'd1);
        check("late_dtack",     32'(dt18),    32'd0);
        as_n = 1'b1; vpa_n = 1'b1;
        repeat (4) tick();
        check("late_release", 32'(dtack_n), 32'd1);

        // AS rises during VMA: VMA_n held to ecnt 0, DTACK never low
        wait_ec1(0);
        as_n = 1'b0; vpa_n = 1'b0;
        repeat (4) tick();
        check("abort_vma_start", 32'(vma_n), 32'd0);
        as_n = 1'b1; vpa_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("abort_vma",   32'(vma_n),   32'(exp_vma_c[k-1]));
            check("abort_dtack", 32'(dtack_n), 32'd1);
        end
        repeat (2) tick();
        check("abort_after_vma",   32'(vma_n),   32'd1);
        check("abort_after_dtack", 32'(dtack_n), 32'd1);

        // Non-VPA cycle: DTACK_MB_n passes through, delayed 3
        as_n = 1'b0;
        repeat (3) tick();
        dtmb_n = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            check("mb_dtack", 32'(dtack_n), 32'(exp_dt_d[j-1]));
            check("mb_vma",   32'(vma_n),   32'd1);
            if (j == 4) check("mb_oe", 32'(dtack_oe), 32'd1);
            if (j == 5) dtmb_n = 1'b1;
        end
        as_n = 1'b1;
        repeat (3) tick();
        check("mb_oe_off", 32'(dtack_oe), 32'd0);

        // IACK with VPA_n low
        fc = 3'b111;
        wait_ec1(0);
        as_n = 1'b0; vpa_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
`ifdef SF500_AUTOVEC_EN
            check("autovec_vma",   32'(vma_n),    32'd1);
            check("autovec_dtack", 32'(dtack_n),  32'd1);
            check("autovec_oe",    32'(dtack_oe), 32'd0);
`else
            check("iack_vma",   32'(vma_n),   32'(exp_vma_a[k-1]));
            check("iack_dtack", 32'(dtack_n), 32'(exp_dt_a[k-1]));
`endif
        end
        as_n = 1'b1; vpa_n = 1'b1; fc = 3'b000;
        repeat (4) tick();
        check("iack_release", 32'(dtack_n), 32'd1);

        // Parameter sweep instance: VMA_n low 4..11, DTACK low from 11
        while ((n % 12) != 11) tick();
        as2_n = 1'b0; vpa2_n = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            check("p12_vma",   32'(vma2_n),   32'(exp_vma_g[k-1]));
            check("p12_dtack", 32'(dtack2_n), 32'(exp_dt_g[k-1]));
        end
        as2_n = 1'b1; vpa2_n = 1'b1;
        repeat (3) tick();
        check("p12_release_hold", 32'(dtack2_n), 32'd0);
        tick();
        check("p12_release", 32'(dtack2_n), 32'd1);

        // Reset pulsed during ACK (ecnt 7 of following period)
        wait_ec1(0);
        as_n = 1'b0; vpa_n = 1'b0;
        repeat (17) tick();
        check("ack_pre_e",     32'(e),        32'd1);
        check("ack_pre_vma",   32'(vma_n),    32'd1);
        check("ack_pre_dtack", 32'(dtack_n),  32'd0);
        check("ack_pre_oe",    32'(dtack_oe), 32'd1);
        RESET_n = 1'b0;
        tick();
        check("ack_rst_e",     32'(e),        32'd0);
        check("ack_rst_vma",   32'(vma_n),    32'd1);
        check("ack_rst_dtack", 32'(dtack_n),  32'd1);
        check("ack_rst_oe",    32'(dtack_oe), 32'd0);
        as_n = 1'b1; vpa_n = 1'b1;
        tick();
        RESET_n = 1'b1;
        n = 0;
        repeat (6) tick();
        check("post_rst_e",     32'(e),       32'd1);
        check("post_rst_dtack", 32'(dtack_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
